// File: rtl/ct_spsram_arb_pkg.sv
// Shared sizes and controller state type for the single-port SRAM arbiter/controller.
package ct_spsram_arb_pkg;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned LANES = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ct_spsram_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins; on a tie the port that was not granted
// most recently wins. The favour pointer moves only when a grant is issued.
module ct_spsram_rr_arb2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // prio_q = 0 favours port 0 on a tie, 1 favours port 1
    logic prio_q, prio_d;

    // Grant decision for the current cycle
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (en_i) begin
            if (req0_i && req1_i) begin
                gnt0_o = ~prio_q;
                gnt1_o = prio_q;
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
    end

    // After a grant, favour the other port; hold when nothing is granted
    always_comb begin
        prio_d = prio_q;
        if (gnt0_o) begin
            prio_d = 1'b1;
        end else if (gnt1_o) begin
            prio_d = 1'b0;
        end
    end

    // Favour pointer register, resets to favour port 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ct_spsram_arb_ctrl.sv
// Two-requester controller for a single-port SRAM: round-robin access, 1-cycle read latency,
// per-lane write masks. Optional power-on clear of every entry when CT_SPSRAM_INIT_CLR_EN is
// defined; otherwise the controller comes out of reset ready to grant.
module ct_spsram_arb_ctrl
    import ct_spsram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 96,
    parameter int unsigned WRAP_SIZE  = 24
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  r0_req,
    input  logic                  r0_wr,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [LANES-1:0]      r0_wmask,
    output logic                  r0_gnt,
    output logic                  r0_rvld,
    input  logic                  r1_req,
    input  logic                  r1_wr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic [LANES-1:0]      r1_wmask,
    output logic                  r1_gnt,
    output logic                  r1_rvld,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  init_busy
);

    logic                  run;
    logic                  clearing;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  gnt0, gnt1;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [LANES-1:0]      sel_wmask;
    logic [DATA_WIDTH-1:0] sel_wen;
    logic                  r0_rvld_q, r1_rvld_q;

`ifdef CT_SPSRAM_INIT_CLR_EN
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Controller state and clear pointer
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Step through every entry, then move to RUN after the last one is cleared
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // State-derived controls
    always_comb begin
        init_busy = (state_q == INIT);
        clearing  = (state_q == INIT);
        run       = (state_q == RUN);
        clr_addr  = cnt_q;
    end
`else
    assign init_busy = 1'b0;
    assign clearing  = 1'b0;
    assign run       = 1'b1;
    assign clr_addr  = '0;
`endif

    ct_spsram_rr_arb2 u_arb (
        .clk_i  (forever_cpuclk),
        .rst_ni (cpurst_b),
        .en_i   (run & cpurst_b),
        .req0_i (r0_req),
        .req1_i (r1_req),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    // Route the granted requester's command to the SRAM side
    always_comb begin
        sel_wr    = gnt1 ? r1_wr    : r0_wr;
        sel_addr  = gnt1 ? r1_addr  : r0_addr;
        sel_wdata = gnt1 ? r1_wdata : r0_wdata;
        sel_wmask = gnt1 ? r1_wmask : r0_wmask;
    end

    // Expand lane mask into active-low bit write enables; reads write nothing
    always_comb begin
        sel_wen = '1;
        for (int i = 0; i < LANES; i++) begin
            sel_wen[i*WRAP_SIZE +: WRAP_SIZE] = {WRAP_SIZE{~(sel_wmask[i] & sel_wr)}};
        end
    end

    // SRAM port: clear write, granted access, or fully idle (also while in reset)
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (cpurst_b) begin
            if (clearing) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = clr_addr;
            end else if (gnt0 || gnt1) begin
                sram_cen  = 1'b0;
                sram_gwen = ~sel_wr;
                sram_wen  = sel_wen;
                sram_a    = sel_addr;
                sram_d    = sel_wdata;
            end
        end
    end

    // Read-valid flags, one cycle after a granted read
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r0_rvld_q <= 1'b0;
            r1_rvld_q <= 1'b0;
        end else begin
            r0_rvld_q <= gnt0 & ~r0_wr;
            r1_rvld_q <= gnt1 & ~r1_wr;
        end
    end

    assign r0_gnt  = gnt0;
    assign r1_gnt  = gnt1;
    assign r0_rvld = r0_rvld_q;
    assign r1_rvld = r1_rvld_q;
    assign rdata   = sram_q;

endmodule

// File: tb/tb_ct_spsram_arb_ctrl.sv
// Bench for ct_spsram_arb_ctrl with a behavioural SRAM and a word-level reference memory.
// Covers the CT_SPSRAM_INIT_CLR_EN build when that macro is defined, otherwise the plain build.
module tb_ct_spsram_arb_ctrl;

    localparam int AW = 9;
    localparam int DW = 96;
    localparam int WS = 24;
    localparam int NL = 4;
    localparam logic [DW-1:0] WEN_0011   = {{48{1'b1}}, {48{1'b0}}};
    localparam logic [DW-1:0] LANE2_ONLY = {24'h0, 24'hFFFFFF, 48'h0};
    localparam logic [DW-1:0] PAT_A5     = {12{8'hA5}};

    logic          clk;
    logic          rst_n;
    logic          r0_req, r0_wr, r1_req, r1_wr;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic [NL-1:0] r0_wmask, r1_wmask;
    logic          r0_gnt, r0_rvld, r1_gnt, r1_rvld;
    logic [DW-1:0] rdata;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_d, sram_wen, sram_q;
    logic          init_busy;

    int            vecs;
    int            errs;
    int            last_gnt;
    logic [DW-1:0] last_wen;
    logic [DW-1:0] mem     [512];
    logic [DW-1:0] exp_mem [512];

    ct_spsram_arb_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .r0_req         (r0_req),
        .r0_wr          (r0_wr),
        .r0_addr        (r0_addr),
        .r0_wdata       (r0_wdata),
        .r0_wmask       (r0_wmask),
        .r0_gnt         (r0_gnt),
        .r0_rvld        (r0_rvld),
        .r1_req         (r1_req),
        .r1_wr          (r1_wr),
        .r1_addr        (r1_addr),
        .r1_wdata       (r1_wdata),
        .r1_wmask       (r1_wmask),
        .r1_gnt         (r1_gnt),
        .r1_rvld        (r1_rvld),
        .rdata          (rdata),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_d         (sram_d),
        .sram_wen       (sram_wen),
        .sram_q         (sram_q),
        .init_busy      (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up garbage in the SRAM, known to the reference model
    function automatic logic [DW-1:0] seed_word(input int a);
        return {32'(a) * 32'h9E3779B1, 32'(a) ^ 32'hDEADBEEF, ~32'(a)};
    endfunction

    // Behavioural single-port SRAM, 1-cycle read, active-low bit write enables
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = seed_word(i);
        forever begin
            @(posedge clk);
            if (sram_cen === 1'b0) begin
                if (sram_gwen === 1'b0) begin
                    mem[sram_a] = (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
                end else begin
                    sram_q = mem[sram_a];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Bit write-enable pattern the SRAM must see for a lane mask
    function automatic logic [DW-1:0] exp_wen(input logic wr, input logic [NL-1:0] m);
        logic [DW-1:0] w;
        w = '1;
        if (wr) for (int b = 0; b < DW; b++) w[b] = ~m[b/WS];
        return w;
    endfunction

    task automatic drive(input int p, input logic req, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NL-1:0] m);
        if (p == 0) begin
            r0_req = req; r0_wr = wr; r0_addr = a; r0_wdata = d; r0_wmask = m;
        end else begin
            r1_req = req; r1_wr = wr; r1_addr = a; r1_wdata = d; r1_wmask = m;
        end
    endtask

    // One access by port p with the other port idle; call just after a falling edge
    task automatic access(input int p, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NL-1:0] m);
        int k;
        k = 0;
        drive(p, 1'b1, wr, a, d, m);
        #1;
        while (((p == 0) ? r0_gnt : r1_gnt) !== 1'b1 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk1("gnt", (p == 0) ? r0_gnt : r1_gnt, 1'b1);
        chk("gnt_wait", DW'(k), '0);
        chk1("gnt_other", (p == 0) ? r1_gnt : r0_gnt, 1'b0);
        chk1("cen", sram_cen, 1'b0);
        chk("addr", DW'(sram_a), DW'(a));
        chk1("gwen", sram_gwen, ~wr);
        chk("wdata", sram_d, d);
        chk("wen", sram_wen, exp_wen(wr, m));
        last_wen = sram_wen;
        last_gnt = p;
        @(negedge clk);
        drive(p, 1'b0, 1'b0, '0, '0, '0);
        chk1("rvld", (p == 0) ? r0_rvld : r1_rvld, ~wr);
        chk1("rvld_other", (p == 0) ? r1_rvld : r0_rvld, 1'b0);
        if (!wr) chk("rdata", rdata, exp_mem[a]);
        else for (int b = 0; b < DW; b++) if (m[b/WS]) exp_mem[a][b] = d[b];
        #1;
        chk1("idle_cen", sram_cen, 1'b1);
        chk1("idle_gwen", sram_gwen, 1'b1);
        chk("idle_wen", sram_wen, '1);
        chk("idle_a", DW'(sram_a), '0);
        chk("idle_d", sram_d, '0);
    endtask

    // Both ports read continuously for n cycles; winners must alternate
    task automatic contend(input int n);
        logic [AW-1:0] a0, a1, pa;
        int w;
        a0 = AW'($urandom);
        a1 = AW'($urandom);
        drive(0, 1'b1, 1'b0, a0, '0, '0);
        drive(1, 1'b1, 1'b0, a1, '0, '0);
        for (int c = 0; c < n; c++) begin
            #1;
            w = (last_gnt == 0) ? 1 : 0;
            chk1("rr_gnt0", r0_gnt, w == 0);
            chk1("rr_gnt1", r1_gnt, w == 1);
            pa = (w == 0) ? a0 : a1;
            chk("rr_addr", DW'(sram_a), DW'(pa));
            last_gnt = w;
            @(negedge clk);
            chk1("rr_rvld0", r0_rvld, w == 0);
            chk1("rr_rvld1", r1_rvld, w == 1);
            chk("rr_rdata", rdata, exp_mem[pa]);
            if (w == 0) begin
                a0 = AW'($urandom);
                r0_addr = a0;
            end else begin
                a1 = AW'($urandom);
                r1_addr = a1;
            end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            access($urandom_range(0, 1), 1'($urandom), AW'(9'h100 + $urandom_range(0, 15)),
                   {$urandom, $urandom, $urandom}, NL'($urandom));
        end
    endtask

`ifdef CT_SPSRAM_INIT_CLR_EN
    // Check n cycles of the clear sequence; call just after reset release at a falling edge
    task automatic run_init(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk1("init_busy", init_busy, 1'b1);
            chk1("init_cen", sram_cen, 1'b0);
            chk1("init_gwen", sram_gwen, 1'b0);
            chk("init_wen", sram_wen, '0);
            chk("init_d", sram_d, '0);
            chk("init_a", DW'(sram_a), DW'(i));
            chk1("init_gnt0", r0_gnt, 1'b0);
            chk1("init_gnt1", r1_gnt, 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < 512; i++) exp_mem[i] = '0;
    endtask
`endif

    initial begin
        vecs = 0;
        errs = 0;
        last_gnt = 1;
        for (int i = 0; i < 512; i++) exp_mem[i] = seed_word(i);
        drive(0, 1'b1, 1'b0, '0, '0, '0);
        drive(1, 1'b1, 1'b0, '0, '0, '0);
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;

        // Requests during reset are ignored and the SRAM stays deselected
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_gnt0", r0_gnt, 1'b0);
        chk1("rst_gnt1", r1_gnt, 1'b0);
        chk1("rst_cen", sram_cen, 1'b1);
        chk1("rst_rvld0", r0_rvld, 1'b0);
        chk1("rst_rvld1", r1_rvld, 1'b0);
`ifdef CT_SPSRAM_INIT_CLR_EN
        chk1("rst_busy", init_busy, 1'b1);
`else
        chk1("rst_busy", init_busy, 1'b0);
`endif
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        drive(0, 1'b1, 1'b0, 9'h055, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef CT_SPSRAM_INIT_CLR_EN
        run_init(512);
`endif
        chk1("run_busy", init_busy, 1'b0);
        access(0, 1'b0, 9'h055, '0, '0);

        // Full write then read back
        access(0, 1'b1, 9'h123, PAT_A5, 4'hF);
        access(0, 1'b0, 9'h123, '0, '0);
        chk("a5_rdata", rdata, PAT_A5);

        // Top address, low two lanes only
        access(0, 1'b1, 9'h1FF, {$urandom, $urandom, $urandom}, 4'b0011);
        chk("wen_0011", last_wen, WEN_0011);
        access(1, 1'b0, 9'h1FF, '0, '0);

        // Lane 2 of all ones over zero
        access(1, 1'b1, 9'h0FF, '0, 4'hF);
        access(1, 1'b1, 9'h0FF, '1, 4'b0100);
        access(1, 1'b0, 9'h0FF, '0, '0);
        chk("lane2_rdata", rdata, LANE2_ONLY);

        contend(6);
        random_ops(40);

        // Reset while a read result is pending drops the valid at once
        drive(1, 1'b1, 1'b0, 9'h123, '0, '0);
        #1;
        chk1("mr_gnt", r1_gnt, 1'b1);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        chk1("mr_rvld", r1_rvld, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mr_rvld_drop", r1_rvld, 1'b0);
        chk1("mr_cen", sram_cen, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        last_gnt = 1;

`ifdef CT_SPSRAM_INIT_CLR_EN
        // Reset in the middle of the clear restarts it from entry 0
        run_init(200);
        #1;
        chk("mi_a200", DW'(sram_a), DW'(200));
        rst_n = 1'b0;
        #1;
        chk1("mi_cen", sram_cen, 1'b1);
        chk1("mi_busy", init_busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_init(512);
`endif
        chk1("post_busy", init_busy, 1'b0);
        access(1, 1'b0, 9'h123, '0, '0);
        contend(4);
        random_ops(20);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
